// File: rtl/register_file.sv
// Architectural register file with rename tags: combinational reads with commit
// forwarding, in-order commit, rename at issue and flush of all renames.

module reg_entry #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 commit_hit,
    input  logic [TAG_WIDTH-1:0] commit_tag,
    input  logic [XLEN-1:0]      commit_data,
    input  logic                 rename_hit,
    input  logic [TAG_WIDTH-1:0] rename_tag,
    input  logic                 flush,
    output logic [XLEN-1:0]      value,
    output logic [TAG_WIDTH-1:0] tag
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
            tag   <= '0;
        end else begin
            if (commit_hit)
                value <= commit_data;
            // flush beats rename, rename beats a commit retiring the old producer
            if (flush)
                tag <= '0;
            else if (rename_hit)
                tag <= rename_tag;
            else if (commit_hit && tag == commit_tag)
                tag <= '0;
        end
    end
endmodule

module register_file #(
    parameter int REG_COUNT = 32,
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           dec_rs1_in,
    input  logic [4:0]           dec_rs2_in,
    output logic [XLEN-1:0]      dec_Vj_out,
    output logic [XLEN-1:0]      dec_Vk_out,
    output logic [TAG_WIDTH-1:0] dec_Qj_out,
    output logic [TAG_WIDTH-1:0] dec_Qk_out,
    input  logic                 dec_rename_signal_in,
    input  logic [4:0]           dec_rd_in,
    input  logic [TAG_WIDTH-1:0] dec_rename_tag_in,
    input  logic                 rob_commit_signal_in,
    input  logic [TAG_WIDTH-1:0] rob_commit_tag_in,
    input  logic [XLEN-1:0]      rob_commit_data_in,
    input  logic [4:0]           rob_commit_target_in,
    input  logic                 flush_signal_in,
    output logic [5:0]           busy_cnt_out
);
    logic [REG_COUNT-1:0][XLEN-1:0]      values;
    logic [REG_COUNT-1:0][TAG_WIDTH-1:0] tags;

    genvar r;
    generate
        for (r = 0; r < REG_COUNT; r++) begin : g_reg
            if (r == 0) begin : g_zero
                assign values[r] = '0;
                assign tags[r]   = '0;
            end else begin : g_ent
                logic commit_hit;
                logic rename_hit;
                assign commit_hit = rob_commit_signal_in && (rob_commit_target_in == 5'(r));
                assign rename_hit = dec_rename_signal_in && (dec_rd_in == 5'(r)) &&
                                    (dec_rename_tag_in != '0);
                reg_entry #(.XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH)) u_entry (
                    .clk         (clk),
                    .rst         (rst),
                    .commit_hit  (commit_hit),
                    .commit_tag  (rob_commit_tag_in),
                    .commit_data (rob_commit_data_in),
                    .rename_hit  (rename_hit),
                    .rename_tag  (dec_rename_tag_in),
                    .flush       (flush_signal_in),
                    .value       (values[r]),
                    .tag         (tags[r])
                );
            end
        end
    endgenerate

    logic [1:0][4:0]           src;
    logic [1:0][XLEN-1:0]      rd_val;
    logic [1:0][TAG_WIDTH-1:0] rd_tag;

    assign src = {dec_rs2_in, dec_rs1_in};

    // Reads see pre-edge state; a commit retiring the current producer forwards.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val[p] = '0;
            rd_tag[p] = '0;
            for (int i = 1; i < REG_COUNT; i++) begin
                if (src[p] == 5'(i)) begin
                    if (rob_commit_signal_in && rob_commit_target_in == src[p] &&
                        rob_commit_tag_in == tags[i]) begin
                        rd_val[p] = rob_commit_data_in;
                        rd_tag[p] = '0;
                    end else begin
                        rd_val[p] = values[i];
                        rd_tag[p] = tags[i];
                    end
                end
            end
        end
    end

    assign dec_Vj_out = rd_val[0];
    assign dec_Vk_out = rd_val[1];
    assign dec_Qj_out = rd_tag[0];
    assign dec_Qk_out = rd_tag[1];

    always_comb begin
        busy_cnt_out = '0;
        for (int i = 1; i < REG_COUNT; i++)
            busy_cnt_out = busy_cnt_out + 6'(tags[i] != '0);
    end
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus a randomized
// run compared against an array-based model of the register/tag state.

module tb_register_file;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, rd, ctgt;
    logic [31:0] vj, vk, cdata;
    logic [3:0]  qj, qk, rtag, ctag;
    logic        ren, cv, flush;
    logic [5:0]  busy;

    int checks = 0;
    int failures = 0;

    logic [31:0] mval [32];
    logic [3:0]  mtag [32];

    always #5 clk = ~clk;

    register_file dut (
        .clk                  (clk),
        .rst                  (rst),
        .dec_rs1_in           (rs1),
        .dec_rs2_in           (rs2),
        .dec_Vj_out           (vj),
        .dec_Vk_out           (vk),
        .dec_Qj_out           (qj),
        .dec_Qk_out           (qk),
        .dec_rename_signal_in (ren),
        .dec_rd_in            (rd),
        .dec_rename_tag_in    (rtag),
        .rob_commit_signal_in (cv),
        .rob_commit_tag_in    (ctag),
        .rob_commit_data_in   (cdata),
        .rob_commit_target_in (ctgt),
        .flush_signal_in      (flush),
        .busy_cnt_out         (busy)
    );

    function automatic logic [31:0] exp_v(input logic [4:0] s);
        if (s == 0) return 32'h0;
        if (cv && ctgt == s && ctag == mtag[s]) return cdata;
        return mval[s];
    endfunction

    function automatic logic [3:0] exp_t(input logic [4:0] s);
        if (s == 0) return 4'h0;
        if (cv && ctgt == s && ctag == mtag[s]) return 4'h0;
        return mtag[s];
    endfunction

    function automatic int exp_busy();
        int n = 0;
        for (int i = 0; i < 32; i++) if (mtag[i] != 0) n++;
        return n;
    endfunction

    // Next-state of the architectural model from the current request set.
    task automatic model_step();
        logic [3:0] nt [32];
        for (int i = 0; i < 32; i++) nt[i] = mtag[i];
        if (cv && ctgt != 0) begin
            mval[ctgt] = cdata;
            if (mtag[ctgt] == ctag) nt[ctgt] = 4'h0;
        end
        if (ren && rd != 0 && rtag != 0) nt[rd] = rtag;
        if (flush) for (int i = 0; i < 32; i++) nt[i] = 4'h0;
        for (int i = 0; i < 32; i++) mtag[i] = nt[i];
    endtask

    task automatic idle();
        ren = 0; cv = 0; flush = 0;
        rd = 0; rtag = 0; ctag = 0; cdata = 0; ctgt = 0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin mval[i] = 0; mtag[i] = 0; end
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        model_clear();
        #3;
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic rename(input logic [4:0] r, input logic [3:0] t);
        idle(); ren = 1; rd = r; rtag = t;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        rename(5'd5, 4'd3);
        rename(5'd6, 4'd4);
        cv = 1; ctgt = 5'd6; ctag = 4'd9; cdata = 32'hDEAD;
        cycle();
        idle();
        rs1 = 5'd6; rs2 = 5'd5;
        #2;
        rst = 0;
        model_clear();
        #1;
        checks++; if (busy !== 6'd0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy); end
        checks++; if (vj !== 32'h0 || qj !== 4'h0) begin failures++; $display("FAIL reset_rs1 got=%h/%0d exp=0/0", vj, qj); end
        checks++; if (vk !== 32'h0 || qk !== 4'h0) begin failures++; $display("FAIL reset_rs2 got=%h/%0d exp=0/0", vk, qk); end
        rst = 1;
        @(posedge clk); #1;
        cv = 1; ctgt = 5'd0; ctag = 4'd3; cdata = 32'hFFFF;
        ren = 1; rd = 5'd0; rtag = 4'd7;
        rs1 = 5'd0; rs2 = 5'd0;
        #1;
        checks++; if (vj !== 32'h0 || qj !== 4'h0) begin failures++; $display("FAIL x0_fwd got=%h/%0d exp=0/0", vj, qj); end
        cycle();
        idle();
        #1;
        checks++; if (vj !== 32'h0 || vk !== 32'h0 || qj !== 4'h0) begin failures++; $display("FAIL x0_write got=%h/%h/%0d exp=0/0/0", vj, vk, qj); end
        checks++; if (busy !== 6'd0) begin failures++; $display("FAIL x0_busy got=%0d exp=0", busy); end
    endtask

    task automatic test_rename_commit();
        do_reset();
        rename(5'd5, 4'd2);
        rs1 = 5'd5; #1;
        checks++; if (qj !== 4'd2) begin failures++; $display("FAIL rc_qj got=%0d exp=2", qj); end
        checks++; if (busy !== 6'd1) begin failures++; $display("FAIL rc_busy got=%0d exp=1", busy); end
        cv = 1; ctag = 4'd2; ctgt = 5'd5; cdata = 32'h1234; #1;
        checks++; if (vj !== 32'h1234 || qj !== 4'd0) begin failures++; $display("FAIL rc_fwd got=%h/%0d exp=1234/0", vj, qj); end
        cycle();
        idle(); #1;
        checks++; if (vj !== 32'h1234 || qj !== 4'd0) begin failures++; $display("FAIL rc_after got=%h/%0d exp=1234/0", vj, qj); end
        checks++; if (busy !== 6'd0) begin failures++; $display("FAIL rc_busy0 got=%0d exp=0", busy); end
    endtask

    task automatic test_stale_commit();
        do_reset();
        rename(5'd7, 4'd2);
        rename(5'd7, 4'd4);
        rs1 = 5'd7;
        cv = 1; ctag = 4'd2; ctgt = 5'd7; cdata = 32'hAA; #1;
        checks++; if (vj !== 32'h0 || qj !== 4'd4) begin failures++; $display("FAIL stale_nofwd got=%h/%0d exp=0/4", vj, qj); end
        cycle();
        idle(); #1;
        checks++; if (vj !== 32'hAA || qj !== 4'd4) begin failures++; $display("FAIL stale_after got=%h/%0d exp=aa/4", vj, qj); end
    endtask

    task automatic test_rename_read();
        do_reset();
        cv = 1; ctag = 4'd1; ctgt = 5'd9; cdata = 32'h55;
        cycle();
        idle();
        rs1 = 5'd9; ren = 1; rd = 5'd9; rtag = 4'd6; #1;
        checks++; if (vj !== 32'h55 || qj !== 4'd0) begin failures++; $display("FAIL rr_same got=%h/%0d exp=55/0", vj, qj); end
        cycle();
        idle(); #1;
        checks++; if (vj !== 32'h55 || qj !== 4'd6) begin failures++; $display("FAIL rr_next got=%h/%0d exp=55/6", vj, qj); end
    endtask

    task automatic test_flush();
        do_reset();
        rename(5'd1, 4'd1);
        rename(5'd2, 4'd2);
        rename(5'd3, 4'd3);
        checks++; if (busy !== 6'd3) begin failures++; $display("FAIL fl_pre got=%0d exp=3", busy); end
        flush = 1; ren = 1; rd = 5'd4; rtag = 4'd5;
        cv = 1; ctgt = 5'd1; ctag = 4'd7; cdata = 32'h77;
        cycle();
        idle();
        rs1 = 5'd1; rs2 = 5'd4; #1;
        checks++; if (busy !== 6'd0) begin failures++; $display("FAIL fl_busy got=%0d exp=0", busy); end
        checks++; if (vj !== 32'h77 || qj !== 4'd0) begin failures++; $display("FAIL fl_x1 got=%h/%0d exp=77/0", vj, qj); end
        checks++; if (qk !== 4'd0) begin failures++; $display("FAIL fl_x4 got=%0d exp=0", qk); end
        rs1 = 5'd2; rs2 = 5'd3; #1;
        checks++; if (qj !== 4'd0 || qk !== 4'd0) begin failures++; $display("FAIL fl_x23 got=%0d/%0d exp=0/0", qj, qk); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 31));
            ren = ($urandom_range(0, 2) != 0);
            rd = 5'($urandom_range(0, 7));
            rtag = 4'($urandom_range(0, 15));
            cv = ($urandom_range(0, 1) != 0);
            ctgt = 5'($urandom_range(0, 7));
            ctag = ($urandom_range(0, 1) != 0) ? mtag[ctgt] : 4'($urandom_range(1, 15));
            cdata = $urandom;
            flush = ($urandom_range(0, 31) == 0);
            if (ren && cv && rd == ctgt && rtag == ctag) rtag = rtag + 4'd1;
            #1;
            checks++;
            if (vj !== exp_v(rs1) || qj !== exp_t(rs1) || vk !== exp_v(rs2) || qk !== exp_t(rs2) ||
                busy !== 6'(exp_busy())) begin
                failures++;
                $display("FAIL rnd[%0d] got=%h/%0d %h/%0d b%0d exp=%h/%0d %h/%0d b%0d", n,
                         vj, qj, vk, qk, busy, exp_v(rs1), exp_t(rs1), exp_v(rs2), exp_t(rs2), exp_busy());
            end
            cycle();
        end
        idle();
    endtask

    initial begin
        rst = 1; rs1 = 0; rs2 = 0;
        idle();
        model_clear();
        #2;
        test_reset();
        test_rename_commit();
        test_stale_commit();
        test_rename_read();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
